// File: rtl/data_memory_bank_if.sv
// Request/response bus between the load/store logic and the data memory bank.
// The master issues accesses; the slave answers with a one-cycle registered response.
interface data_memory_bank_if #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_memory_bank.sv
// Single-port data memory with byte-lane writes, one-cycle read latency and a
// post-reset fill sweep; accesses at or beyond DEPTH are flagged and have no effect.
module data_memory_bank #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_bank_if.slave   bus_io
);
  localparam int NB = DATA_W / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, rvalid_q, rvalid_d, err_q, err_d;
  logic                acc, rd_en, in_range, sweep_last;
  logic [ADDR_W-1:0]   acc_idx, wr_idx;
  logic [DATA_W-1:0]   wr_data, fill_word;
  logic [NB-1:0]       wr_be;
  wire  [DATA_W-1:0]   rdata_w;

  // Full 32-bit compare so large addresses never alias into the array.
  assign in_range   = bus_io.addr < 32'(DEPTH);
  assign acc_idx    = bus_io.addr[ADDR_W-1:0];
  assign sweep_last = (cnt_q == ADDR_W'(DEPTH - 1));
  assign fill_word  = (INIT_MODE == 1) ? DATA_W'(cnt_q) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (sweep_last) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    acc      = (state_q == ST_RUN) && bus_io.req;
    rd_en    = acc && !bus_io.we;
    rvalid_d = rd_en;
    err_d    = acc && !in_range;
    wr_idx   = cnt_q;
    wr_data  = fill_word;
    wr_be    = '0;
    // Reset has priority: nothing is written on an edge with rst_n low.
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        wr_be = '1;
      end else if (acc && bus_io.we && in_range) begin
        wr_idx  = acc_idx;
        wr_data = bus_io.wdata;
        wr_be   = bus_io.be;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q  <= (state_d == ST_RUN);
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // One narrow RAM per byte lane keeps byte enables a plain per-lane write enable.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_be[gi]) begin
          ram[wr_idx] <= wr_data[gi*8 +: 8];
        end
        if (!rst_n) begin
          rd_q <= '0;
        end else if (rd_en) begin
          rd_q <= in_range ? ram[acc_idx] : 8'h00;
        end
      end

      assign rdata_w[gi*8 +: 8] = rd_q;
    end
  endgenerate

  assign bus_io.ready  = ready_q;
  assign bus_io.rvalid = rvalid_q;
  assign bus_io.err    = err_q;
  assign bus_io.rdata  = rdata_w;
endmodule

// File: tb/tb_data_memory_bank.sv
// Directed and random accesses on two configurations of data_memory_bank,
// compared against a word-array reference model.
module tb_data_memory_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_a [256];
  logic [15:0] model_b [100];
  logic [31:0] last_a, last_b;

  data_memory_bank_if #(.DATA_W(32)) bus_a ();
  data_memory_bank_if #(.DATA_W(16)) bus_b ();

  data_memory_bank #(.DATA_W(32), .DEPTH(256), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus_io(bus_a)
  );
  data_memory_bank #(.DATA_W(16), .DEPTH(100), .INIT_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus_io(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (!b) begin
      bus_a.req = req; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata; bus_a.be = be;
    end else begin
      bus_b.req = req; bus_b.we = we; bus_b.addr = addr;
      bus_b.wdata = wdata[15:0]; bus_b.be = be[1:0];
    end
  endtask

  function automatic logic [31:0] obs_rdata(input bit b);
    return b ? {16'h0, bus_b.rdata} : bus_a.rdata;
  endfunction

  task automatic access(input bit b, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input string tag);
    int depth = b ? 100 : 256;
    int nb    = b ? 2 : 4;
    bit inr   = (addr < 32'(depth));
    logic [31:0] exp_d;
    drive(b, 1'b1, we, addr, wdata, be);
    if (we) begin
      if (inr) begin
        for (int k = 0; k < nb; k++) begin
          if (be[k]) begin
            if (b) model_b[addr[6:0]][8*k +: 8] = wdata[8*k +: 8];
            else   model_a[addr[7:0]][8*k +: 8] = wdata[8*k +: 8];
          end
        end
      end
      exp_d = b ? last_b : last_a;
    end else begin
      exp_d = !inr ? 32'h0 : (b ? {16'h0, model_b[addr[6:0]]} : model_a[addr[7:0]]);
    end
    if (b) last_b = exp_d; else last_a = exp_d;
    @(posedge clk); #1;
    check({tag, " rvalid"}, 32'(b ? bus_b.rvalid : bus_a.rvalid), 32'(!we));
    check({tag, " err"},    32'(b ? bus_b.err : bus_a.err),       32'(!inr));
    check({tag, " rdata"},  obs_rdata(b), exp_d);
    check({tag, " ready"},  32'(b ? bus_b.ready : bus_a.ready),   32'd1);
  endtask

  task automatic idle(input bit b, input string tag);
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check({tag, " rvalid"}, 32'(b ? bus_b.rvalid : bus_a.rvalid), 32'd0);
    check({tag, " err"},    32'(b ? bus_b.err : bus_a.err),       32'd0);
    check({tag, " rdata"},  obs_rdata(b), b ? last_b : last_a);
  endtask

  // Requests are held high throughout the sweep; none may be answered.
  task automatic wait_ready(input bit b, input int exp_edges, input string tag);
    int n = 0;
    int bad = 0;
    drive(b, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    while (!(b ? bus_b.ready : bus_a.ready) && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if ((b ? bus_b.rvalid : bus_a.rvalid) || (b ? bus_b.err : bus_a.err)) bad++;
    end
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, " edges"}, 32'(n), 32'(exp_edges));
    check({tag, " req_ignored"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst ready",  32'(bus_a.ready),  32'd0);
    check("rst rvalid", 32'(bus_a.rvalid), 32'd0);
    check("rst err",    32'(bus_a.err),    32'd0);
    check("rst rdata",  bus_a.rdata,       32'd0);

    // Interrupt the first sweep at count 100; the sweep must restart from 0.
    rst_a = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("mid_init ready", 32'(bus_a.ready), 32'd0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    wait_ready(0, 256, "init_a");
    for (int i = 0; i < 256; i++) model_a[i] = 32'(i);
    last_a = 32'h0;

    access(0, 0, 32'd0,   32'h0, 4'h0, "rd0");
    access(0, 0, 32'd5,   32'h0, 4'h0, "rd5");
    access(0, 0, 32'd255, 32'h0, 4'h0, "rd255");
    idle(0, "idle1");
    access(0, 1, 32'd10, 32'hAABBCCDD, 4'b0101, "wr10_be5");
    access(0, 0, 32'd10, 32'h0, 4'h0, "rd10_be5");
    access(0, 1, 32'd10, 32'h12345678, 4'b1111, "wr10_full");
    access(0, 0, 32'd10, 32'h0, 4'h0, "rd10_full");
    idle(0, "idle2");
    access(0, 0, 32'd1, 32'h0, 4'h0, "b2b1");
    access(0, 0, 32'd2, 32'h0, 4'h0, "b2b2");
    access(0, 0, 32'd3, 32'h0, 4'h0, "b2b3");
    access(0, 1, 32'd7, 32'hFFFF0000, 4'hF, "wr7");
    access(0, 0, 32'd7, 32'h0, 4'h0, "raw7");
    idle(0, "idle3");
    access(0, 0, 32'd256, 32'h0, 4'h0, "oor_rd");
    access(0, 1, 32'h100000FF, 32'hDEADBEEF, 4'hF, "oor_wr");
    access(0, 0, 32'd255, 32'h0, 4'h0, "alias255");
    access(0, 1, 32'd20, 32'hCAFEF00D, 4'h0, "wr_be0");
    access(0, 0, 32'd20, 32'h0, 4'h0, "rd_be0");
    idle(0, "idle4");

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(0, "rand_idle_a");
      end else begin
        addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 280));
        access(0, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), "rand_a");
      end
    end

    // Reset lands on the same edge as a read request: no response may appear.
    drive(0, 1'b1, 1'b0, 32'd10, 32'h0, 4'h0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("run_rst rvalid", 32'(bus_a.rvalid), 32'd0);
    check("run_rst err",    32'(bus_a.err),    32'd0);
    check("run_rst ready",  32'(bus_a.ready),  32'd0);
    check("run_rst rdata",  bus_a.rdata,       32'd0);
    rst_a = 1'b1;
    wait_ready(0, 256, "reinit_a");
    for (int i = 0; i < 256; i++) model_a[i] = 32'(i);
    last_a = 32'h0;
    access(0, 0, 32'd10, 32'h0, 4'h0, "reinit_rd10");
    idle(0, "idle5");

    check("b rst ready", 32'(bus_b.ready), 32'd0);
    rst_b = 1'b1;
    wait_ready(1, 100, "init_b");
    for (int i = 0; i < 100; i++) model_b[i] = 16'h0;
    last_b = 32'h0;
    access(1, 0, 32'd99,  32'h0, 4'h0, "b_rd99");
    access(1, 0, 32'd100, 32'h0, 4'h0, "b_oor");
    access(1, 1, 32'd5, 32'h1234, 4'b11, "b_wr_full");
    access(1, 1, 32'd5, 32'hABCD, 4'b10, "b_wr_hi");
    access(1, 0, 32'd5, 32'h0, 4'h0, "b_rd5");
    idle(1, "b_idle");
    for (int i = 0; i < 80; i++) begin
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 110));
      access(1, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), "rand_b");
    end
    idle(1, "b_idle_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
